// File: rtl/ad7671_scan_ctrl.sv
// Scan controller for four AD7671 ADCs behind an ADG408 mux.
// One start gives settle, shared convert, busy wait and four reads.
module ad7671_scan_ctrl #(
  parameter int SETTLE_CYC  = 8,
  parameter int CNV_CYC     = 2,
  parameter int RD_CYC      = 3,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  chan,
  output logic [2:0]  mux_a,
  output logic        cnvst_n,
  output logic [3:0]  rd_n,
  input  logic [3:0]  busy,
  input  logic [15:0] adc_data,
  output logic [15:0] dout,
  output logic [1:0]  dout_idx,
  output logic        dout_valid,
  output logic        done,
  output logic        idle,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV,
    S_WAIT,
    S_READ,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [15:0] SetLast = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] CnvLast = 16'(CNV_CYC - 1);
  localparam logic [15:0] RdLast  = 16'(RD_CYC - 1);
  localparam logic [15:0] ToLast  = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] BlankLast = 16'd3;

  state_e      state_q, state_d;
  logic [1:0]  rs_q;
  logic        run;
  logic [3:0]  b1_q, bs_q;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  mux_q, mux_d;
  logic        cnv_n_q, cnv_n_d;
  logic [3:0]  rd_n_q, rd_n_d;
  logic [15:0] dout_q, dout_d;
  logic [1:0]  didx_q, didx_d;
  logic        dv_q, dv_d;
  logic        done_q, done_d;
  logic        idle_q, idle_d;
  logic        terr_q, terr_d;

  // Reset asserts asynchronously but releases two edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rs_q <= 2'b00;
    else        rs_q <= {rs_q[0], 1'b1};
  end

  assign run = rs_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1_q <= 4'h0;
      bs_q <= 4'h0;
    end else begin
      b1_q <= busy;
      bs_q <= b1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 2'd0;
      mux_q   <= 3'd0;
      cnv_n_q <= 1'b1;
      rd_n_q  <= 4'hF;
      dout_q  <= 16'd0;
      didx_q  <= 2'd0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mux_q   <= mux_d;
      cnv_n_q <= cnv_n_d;
      rd_n_q  <= rd_n_d;
      dout_q  <= dout_d;
      didx_q  <= didx_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    mux_d   = mux_q;
    dout_d  = dout_q;
    didx_d  = didx_q;
    dv_d    = 1'b0;
    terr_d  = terr_q;
    if (!run) begin
      cnt_d = 16'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = 16'd0;
          if (start) begin
            mux_d   = chan;
            terr_d  = 1'b0;
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SetLast) begin
            cnt_d   = 16'd0;
            state_d = S_CONV;
          end
        end
        S_CONV: begin
          if (cnt_q == CnvLast) begin
            cnt_d   = 16'd0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // First four cycles cover BUSY rise plus sync delay
          if (cnt_q >= BlankLast && bs_q == 4'h0) begin
            cnt_d   = 16'd0;
            idx_d   = 2'd0;
            state_d = S_READ;
          end else if (cnt_q == ToLast) begin
            cnt_d   = 16'd0;
            terr_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_READ: begin
          if (cnt_q == RdLast) begin
            cnt_d   = 16'd0;
            dout_d  = adc_data;
            didx_d  = idx_q;
            dv_d    = 1'b1;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          cnt_d = 16'd0;
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_READ;
          end
        end
        S_DONE: begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end
        default: begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Strobes are registered from the next state so they never glitch
  always_comb begin
    cnv_n_d = (state_d != S_CONV);
    done_d  = (state_d == S_DONE);
    idle_d  = (state_d == S_IDLE);
    rd_n_d  = 4'hF;
    if (state_d == S_READ) rd_n_d = ~(4'(4'b0001 << idx_d));
  end

  assign mux_a       = mux_q;
  assign cnvst_n     = cnv_n_q;
  assign rd_n        = rd_n_q;
  assign dout        = dout_q;
  assign dout_idx    = didx_q;
  assign dout_valid  = dv_q;
  assign done        = done_q;
  assign idle        = idle_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ad7671_scan_ctrl.sv
// Randomized bench for ad7671_scan_ctrl against a cycle-count model.
// Models ADC busy/data behaviour and checks scan timing and captures.
module tb_ad7671_scan_ctrl;

  localparam int S = 8;
  localparam int C = 2;
  localparam int R = 3;
  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  chan;
  logic [2:0]  mux_a;
  logic        cnvst_n;
  logic [3:0]  rd_n;
  logic [3:0]  busy;
  logic [15:0] adc_data;
  logic [15:0] dout;
  logic [1:0]  dout_idx;
  logic        dout_valid;
  logic        done;
  logic        idle;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] rd_base = 16'h0;

  int o_len, o_cnv, o_mux_bad, o_done, o_rd_seen;
  logic o_terr1;
  logic [15:0] o_dat[$];
  logic [1:0]  o_idx[$];

  ad7671_scan_ctrl #(
    .SETTLE_CYC(S),
    .CNV_CYC(C),
    .RD_CYC(R),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .chan(chan),
    .mux_a(mux_a),
    .cnvst_n(cnvst_n),
    .rd_n(rd_n),
    .busy(busy),
    .adc_data(adc_data),
    .dout(dout),
    .dout_idx(dout_idx),
    .dout_valid(dout_valid),
    .done(done),
    .idle(idle),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ADC model: selected chip drives base + chip index
  always_comb begin
    adc_data = 16'hDEAD;
    for (int i = 0; i < 4; i++)
      if (!rd_n[i]) adc_data = rd_base + 16'(i);
  end

  // Strobe exclusivity checked every cycle
  always @(negedge clk) begin
    checks++;
    if (!(rd_n == 4'hF || $onehot(~rd_n)) ||
        (rd_n != 4'hF && !cnvst_n)) begin
      failures++;
      $display("FAIL strobe_excl rd_n=%b cnvst_n=%b", rd_n, cnvst_n);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // busy_s clears 2 cycles after busy; busy rises in first CONV cycle
  function automatic int exp_wait(input int hold);
    int w;
    w = hold + 3 - C;
    return (w < 4) ? 4 : w;
  endfunction

  function automatic int exp_len(input int hold, input bit to);
    if (to) return S + C + T + 1;
    return S + C + exp_wait(hold) + 4 * (R + 1) + 1;
  endfunction

  task automatic do_scan(input logic [2:0] ch, input int hold,
                         input logic [15:0] base, input logic [3:0] stuck,
                         input bit noisy);
    int hl;
    int guard;
    hl = -1;
    guard = 0;
    rd_base = base;
    o_len = 0; o_cnv = 0; o_mux_bad = 0; o_done = 0; o_rd_seen = 0;
    o_terr1 = 1'bx;
    o_dat.delete();
    o_idx.delete();
    busy = 4'h0;
    @(negedge clk);
    start = 1'b1;
    chan = ch;
    @(negedge clk);
    start = 1'b0;
    chan = 3'($urandom);
    while (!idle && guard < 5000) begin
      o_len++;
      if (o_len == 1) o_terr1 = timeout_err;
      if (!cnvst_n) o_cnv++;
      if (mux_a != ch) o_mux_bad++;
      if (rd_n != 4'hF) o_rd_seen++;
      if (dout_valid) begin
        o_dat.push_back(dout);
        o_idx.push_back(dout_idx);
      end
      if (done) o_done++;
      if (!cnvst_n && hl < 0) begin
        hl = hold;
        busy = (hold == 0) ? stuck : 4'hF;
      end else if (hl > 0) begin
        hl--;
        if (hl == 0) busy = stuck;
      end
      if (noisy) begin
        start = done ? 1'b0 : 1'($urandom_range(0, 1));
        chan = 3'($urandom);
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    busy = 4'h0;
  endtask

  task automatic test_reset;
    logic [29:0] got, exp;
    rst_n = 1'b0;
    start = 1'b0;
    chan = 3'd0;
    busy = 4'h0;
    #17;
    got = {mux_a, cnvst_n, rd_n, dout, dout_idx,
           dout_valid, done, idle, timeout_err};
    exp = {3'd0, 1'b1, 4'hF, 16'h0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_vals got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    start = 1'b1;
    chan = 3'd6;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || mux_a !== 3'd0) begin
      failures++;
      $display("FAIL reset_release idle=%b mux_a=%0d exp idle=1 mux_a=0",
               idle, mux_a);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reads(input string nm, input logic [15:0] base);
    checks++;
    if (o_dat.size() != 4) begin
      failures++;
      $display("FAIL %s_nvalid got=%0d exp=4", nm, o_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (o_dat[i] !== base + 16'(i) || o_idx[i] !== 2'(i)) begin
          failures++;
          $display("FAIL %s_rd%0d got=%h/%0d exp=%h/%0d", nm, i,
                   o_dat[i], o_idx[i], base + 16'(i), i);
        end
      end
    end
    checks++;
    if (dout !== base + 16'd3) begin
      failures++;
      $display("FAIL %s_hold dout=%h exp=%h", nm, dout, base + 16'd3);
    end
  endtask

  task automatic check_scan(input string nm, input logic [2:0] ch,
                            input int hold, input logic [15:0] base);
    checks++;
    if (o_len != exp_len(hold, 1'b0)) begin
      failures++;
      $display("FAIL %s_len got=%0d exp=%0d", nm, o_len, exp_len(hold, 1'b0));
    end
    checks++;
    if (o_cnv != C || o_done != 1 || o_mux_bad != 0 || o_terr1 !== 1'b0) begin
      failures++;
      $display("FAIL %s_ctl cnv=%0d done=%0d muxbad=%0d terr=%b exp %0d/1/0/0",
               nm, o_cnv, o_done, o_mux_bad, o_terr1, C);
    end
    checks++;
    if (mux_a !== ch || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_post mux_a=%0d terr=%b exp mux_a=%0d terr=0",
               nm, mux_a, timeout_err, ch);
    end
    check_reads(nm, base);
  endtask

  task automatic test_basic;
    do_scan(3'd5, 20, 16'h1230, 4'h0, 1'b0);
    check_scan("basic", 3'd5, 20, 16'h1230);
  endtask

  task automatic test_no_busy;
    logic [15:0] b;
    logic [2:0] ch;
    b = 16'($urandom);
    ch = 3'($urandom);
    do_scan(ch, 0, b, 4'h0, 1'b0);
    check_scan("nobusy", ch, 0, b);
  endtask

  task automatic test_random_scans;
    for (int n = 0; n < 6; n++) begin
      logic [15:0] b;
      logic [2:0] ch;
      int h;
      b = 16'($urandom);
      ch = 3'($urandom);
      h = $urandom_range(0, 40);
      do_scan(ch, h, b, 4'h0, 1'b0);
      check_scan("rand", ch, h, b);
    end
  endtask

  task automatic test_timeout;
    logic [15:0] prev;
    prev = dout;
    do_scan(3'd2, 0, 16'hBEE0, 4'b0100, 1'b0);
    checks++;
    if (o_len != exp_len(0, 1'b1) || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_len got=%0d terr=%b exp=%0d terr=1",
               o_len, timeout_err, exp_len(0, 1'b1));
    end
    checks++;
    if (o_done != 1 || o_dat.size() != 0 || o_rd_seen != 0) begin
      failures++;
      $display("FAIL timeout_ctl done=%0d nvalid=%0d rdlow=%0d exp 1/0/0",
               o_done, o_dat.size(), o_rd_seen);
    end
    checks++;
    if (dout !== prev) begin
      failures++;
      $display("FAIL timeout_hold dout=%h exp=%h", dout, prev);
    end
    do_scan(3'd1, 7, 16'h4440, 4'h0, 1'b0);
    check_scan("after_to", 3'd1, 7, 16'h4440);
  endtask

  task automatic test_back_to_back;
    int woke;
    logic [15:0] b;
    int h;
    b = 16'($urandom);
    h = $urandom_range(0, 30);
    do_scan(3'd7, h, b, 4'h0, 1'b1);
    check_scan("noisy", 3'd7, h, b);
    woke = 0;
    repeat (6) begin
      @(negedge clk);
      if (!idle) woke++;
    end
    checks++;
    if (woke != 0) begin
      failures++;
      $display("FAIL no_queue nonidle_cycles=%0d exp=0", woke);
    end
    b = 16'($urandom);
    do_scan(3'd4, 12, b, 4'h0, 1'b0);
    check_scan("b2b", 3'd4, 12, b);
  endtask

  task automatic test_reset_midread;
    int guard;
    int nd;
    int ndv;
    logic [7:0] got;
    guard = 0;
    nd = 0;
    ndv = 0;
    rd_base = 16'h7770;
    busy = 4'h0;
    @(negedge clk);
    start = 1'b1;
    chan = 3'd3;
    @(negedge clk);
    start = 1'b0;
    while (rd_n[1] && guard < 300) begin
      if (done) nd++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      failures++;
      $display("FAIL midread_reach rd_n=%b exp rd_n[1] low", rd_n);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {rd_n, cnvst_n, idle, done, dout_valid};
    checks++;
    if (got !== 8'b1111_1100) begin
      failures++;
      $display("FAIL midread_async got=%b exp=11111100", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done) nd++;
      if (dout_valid) ndv++;
    end
    checks++;
    if (nd != 0 || ndv != 0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL midread_quiet done=%0d dv=%0d idle=%b exp 0/0/1",
               nd, ndv, idle);
    end
    do_scan(3'd6, 15, 16'h5550, 4'h0, 1'b0);
    check_scan("post_rst", 3'd6, 15, 16'h5550);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_busy();
    test_random_scans();
    test_timeout();
    test_back_to_back();
    test_reset_midread();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad7671_scan_ctrl.md
AD7671_SCAN_CTRL -- requirements
Module: ad7671_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 8, mux settling time in clk cycles (range 1..255).
REQ-002 The block SHALL have parameter CNV_CYC, default 2, cnvst_n low width in cycles (range 1..15).
REQ-003 The block SHALL have parameter RD_CYC, default 3, rd_n low width per chip in cycles (range 1..15).
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 200, maximum busy wait in cycles (range 8..65535).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: request one scan; sampled only in IDLE.
REQ-008 The block SHALL have port chan, input, 3 bits: analog mux channel for the scan; latched on accepted start.
REQ-009 The block SHALL have port mux_a, output, 3 bits: ADG408 address A2..A0.
REQ-010 The block SHALL have port cnvst_n, output, 1 bit: shared conversion start to all four ADCs (the U1234 WR line).
REQ-011 The block SHALL have port rd_n, output, 4 bits: per-chip read strobe, where bit i drives chip U(i+1).
REQ-012 The block SHALL have port busy, input, 4 bits: ADC BUSY lines, asynchronous, active high.
REQ-013 The block SHALL have port adc_data, input, 16 bits: shared ADC data bus.
REQ-014 The block SHALL have port dout, output, 16 bits: captured sample.
REQ-015 The block SHALL have port dout_idx, output, 2 bits: chip index of dout.
REQ-016 The block SHALL have port dout_valid, output, 1 bit: one-cycle pulse qualifying dout and dout_idx.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle end-of-scan pulse.
REQ-018 The block SHALL have port idle, output, 1 bit: high while in IDLE.
REQ-019 The block SHALL have port timeout_err, output, 1 bit: sticky; cleared on the next accepted start.

Function
REQ-020 The block SHALL pass busy through a 2-flop synchronizer; only the synchronized value (busy_s) is used.
REQ-021 The block SHALL implement the states IDLE, SETTLE, CONV, WAIT, READ, GAP and DONE.
REQ-022 In IDLE, start=1 SHALL latch chan into mux_a, clear timeout_err and enter SETTLE on the next cycle.
REQ-023 Start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-024 The block SHALL remain in SETTLE for exactly SETTLE_CYC cycles, then enter CONV.
REQ-025 In CONV, cnvst_n SHALL be low for exactly CNV_CYC cycles, then the block SHALL enter WAIT.
REQ-026 WAIT SHALL ignore busy_s for its first 4 cycles, covering BUSY rise delay plus synchronizer latency.
REQ-027 After those 4 cycles, WAIT SHALL exit to READ with chip index 0 in the first cycle that busy_s==4'b0000.
REQ-028 If busy_s is not all-zero after TIMEOUT_CYC cycles in WAIT, the block SHALL set timeout_err and enter DONE with no reads and no dout_valid.
REQ-029 In READ for chip i, rd_n[i] SHALL be low for exactly RD_CYC cycles while all other rd_n bits stay high.
REQ-030 On the last low cycle of rd_n[i], adc_data SHALL be registered into dout, with dout_idx=i.
REQ-031 dout_valid SHALL pulse in the cycle after the capture, coinciding with the first GAP cycle.
REQ-032 GAP SHALL last 1 cycle with rd_n=4'hF; i<3 SHALL increment i and enter READ, i==3 SHALL enter DONE.
REQ-033 DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-034 At most one rd_n bit SHALL be low at any time, and rd_n SHALL never be low while cnvst_n is low.
REQ-035 mux_a SHALL be held stable from the latching of chan until the next accepted start.
REQ-036 dout SHALL hold its last value between captures.
REQ-037 Scan length with no timeout SHALL be SETTLE_CYC + CNV_CYC + W + 4*(RD_CYC+1) + 1 cycles, where W is the WAIT cycle count.

Reset
REQ-038 rst_n low SHALL asynchronously force state IDLE and the following values: mux_a=0, cnvst_n=1, rd_n=4'hF, dout=0, dout_idx=0, dout_valid=0, done=0, idle=1, timeout_err=0, and all counters and synchronizer flops to 0.
REQ-039 Reset asserted mid-scan, including mid-read, SHALL release strobes within the same reset assertion, with no completion pulses.
REQ-040 Release of rst_n SHALL be synchronized internally so that the first state change occurs no earlier than the second clk edge after release.

Verification
REQ-041 The bench SHALL cover: start=1 for 1 cycle with chan=5, busy high for 20 cycles after cnvst_n falls, adc_data=16'h1230+i during rd_n[i] low -> mux_a=5; cnvst_n low exactly 2 cycles; four dout_valid pulses with dout 1230/1231/1232/1233 and idx 0..3; done pulse; scan length per REQ-037.
REQ-042 The bench SHALL cover: busy[2] stuck high -> timeout_err=1 after 200 WAIT cycles; done pulse; no dout_valid; rd_n stays 4'hF.
REQ-043 The bench SHALL cover: start pulsed repeatedly during a scan -> exactly one scan completes; a second scan begins only on start sampled in IDLE.
REQ-044 The bench SHALL cover: rst_n low during the rd_n[1] low phase -> rd_n=4'hF and cnvst_n=1 immediately, without waiting for clk; no done pulse; a subsequent start gives a normal scan.
REQ-045 The bench SHALL cover: busy all-zero throughout -> WAIT exits after exactly 4 cycles; reads proceed normally.
REQ-046 The bench SHALL cover, in all runs: assertion of REQ-034 (rd_n one-hot-low or all high; no overlap with cnvst_n).
